skid_register_slice: RTL and testbench

- Valid/ready pipeline register stage with a two-entry skid buffer.
- Registers the forward path (data, valid) and the backward path (ready), so no combinational path crosses the slice in either direction.
- Inserted between streaming compute stages (e.g. matmul feeders, dequant units) wherever timing closure needs a cut and the downstream stage can apply backpressure.
- Sustains one transfer per cycle with one cycle of latency.

---
 rtl/skid_slice_pkg.sv | 12 +
 rtl/skid_slice_ctrl.sv | 115 +++++++++++
 rtl/skid_register_slice.sv | 89 ++++++++
 tb/tb_skid_register_slice.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/skid_slice_pkg.sv
// Shared types for the skid register slice: FSM state encoding and buffer depth.
package skid_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    localparam int unsigned SKID_DEPTH = 32'd2;

endpackage

// File: rtl/skid_slice_ctrl.sv
// Occupancy FSM of the skid slice: registered ready/valid plus per-cycle register load strobes.
module skid_slice_ctrl
    import skid_slice_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in_valid,
    input  logic        data_out_ready,
    output skid_state_t state,
    output logic        load_main,
    output logic        sel_skid,
    output logic        load_skid,
    output logic        data_in_ready,
    output logic        data_out_valid
);

    skid_state_t state_r;
    logic        ready_r;
    logic        valid_r;
    logic        in_fire_s;
    logic        out_fire_s;
    logic        load_main_s;
    logic        sel_skid_s;
    logic        load_skid_s;

    assign in_fire_s  = data_in_valid & ready_r;
    assign out_fire_s = valid_r & data_out_ready;

    // State transitions; ready/valid are set alongside the next state so both stay pure flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_r <= BUSY;
                        ready_r <= 1'b1;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= EMPTY;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    if (in_fire_s && !out_fire_s) begin
                        state_r <= FULL;
                        ready_r <= 1'b0;
                        valid_r <= 1'b1;
                    end else if (!in_fire_s && out_fire_s) begin
                        state_r <= EMPTY;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= BUSY;
                        ready_r <= 1'b1;
                        valid_r <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        state_r <= BUSY;
                        ready_r <= 1'b1;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= FULL;
                        ready_r <= 1'b0;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Payload register strobes for the datapath in the top level.
    always_comb begin
        load_main_s = 1'b0;
        sel_skid_s  = 1'b0;
        load_skid_s = 1'b0;
        case (state_r)
            EMPTY: begin
                load_main_s = in_fire_s;
            end
            BUSY: begin
                load_main_s = in_fire_s & out_fire_s;
                load_skid_s = in_fire_s & ~out_fire_s;
            end
            FULL: begin
                load_main_s = out_fire_s;
                sel_skid_s  = 1'b1;
            end
            default: begin
                load_main_s = 1'b0;
                sel_skid_s  = 1'b0;
                load_skid_s = 1'b0;
            end
        endcase
    end

    assign state          = state_r;
    assign load_main      = load_main_s;
    assign sel_skid       = sel_skid_s;
    assign load_skid      = load_skid_s;
    assign data_in_ready  = ready_r;
    assign data_out_valid = valid_r;

endmodule

// File: rtl/skid_register_slice.sv
// Fully registered valid/ready slice with a two-entry skid buffer.
// Optional stall counter enabled by defining SKID_REGISTER_SLICE_STALL_CNT_EN.
module skid_register_slice
    import skid_slice_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE     = {DATA_WIDTH{1'b0}},
    parameter int unsigned             STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_in_valid,
    output logic                       data_in_ready,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_out_valid,
    input  logic                       data_out_ready,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    skid_state_t           state_s;
    logic                  load_main_s;
    logic                  sel_skid_s;
    logic                  load_skid_s;
    logic                  take_skid_s;
    logic [DATA_WIDTH-1:0] main_next_s;
    logic [DATA_WIDTH-1:0] main_r;
    logic [DATA_WIDTH-1:0] skid_r;

    skid_slice_ctrl u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .data_in_valid  (data_in_valid),
        .data_out_ready (data_out_ready),
        .state          (state_s),
        .load_main      (load_main_s),
        .sel_skid       (sel_skid_s),
        .load_skid      (load_skid_s),
        .data_in_ready  (data_in_ready),
        .data_out_valid (data_out_valid)
    );

    // Skid word only ever refills main when the FSM is actually holding two words.
    assign take_skid_s = sel_skid_s & (state_s == FULL);

    // Source for the main register: drained skid word or fresh upstream word.
    always_comb begin
        if (take_skid_s) begin
            main_next_s = skid_r;
        end else begin
            main_next_s = data_in;
        end
    end

    // Payload registers; main keeps its stale word when the slice drains to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r <= RESET_VALUE;
            skid_r <= RESET_VALUE;
        end else begin
            if (load_main_s) begin
                main_r <= main_next_s;
            end
            if (load_skid_s) begin
                skid_r <= data_in;
            end
        end
    end

    assign data_out = main_r;

`ifdef SKID_REGISTER_SLICE_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_r;

    // Saturating count of cycles where downstream holds off a valid word.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= {STALL_CNT_WIDTH{1'b0}};
        end else if (data_out_valid && !data_out_ready && (stall_r != {STALL_CNT_WIDTH{1'b1}})) begin
            stall_r <= stall_r + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign stall_count = stall_r;
`else
    assign stall_count = {STALL_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_skid_register_slice.sv
// Directed and random bench for skid_register_slice against a queue-based occupancy model.
module tb_skid_register_slice;

    localparam int unsigned DW  = 32;
    localparam int unsigned SCW = 4;
    localparam logic [31:0] RV  = 32'h0000_DEAD;
`ifdef SKID_REGISTER_SLICE_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  data_in = '0;
    logic           data_in_valid = 1'b0;
    logic           data_in_ready;
    logic [DW-1:0]  data_out;
    logic           data_out_valid;
    logic           data_out_ready = 1'b0;
    logic [SCW-1:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic [31:0] last_out;
    int          stall_m;

    skid_register_slice #(
        .DATA_WIDTH      (DW),
        .RESET_VALUE     (RV),
        .STALL_CNT_WIDTH (SCW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_stall;
        exp_stall = STALL_EN ? 32'(stall_m) : 32'd0;
        check({tag, ".valid"}, {31'd0, data_out_valid}, {31'd0, q.size() > 0});
        check({tag, ".ready"}, {31'd0, data_in_ready}, {31'd0, q.size() < 2});
        check({tag, ".data"}, data_out, last_out);
        check({tag, ".stall"}, {28'd0, stall_count}, exp_stall);
    endtask

    // One clock with given inputs; model outputs are checked before the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input string tag);
        bit in_f;
        bit out_f;
        data_in_valid  = v;
        data_in        = d;
        data_out_ready = r;
        #1;
        check_model(tag);
        in_f  = v && (q.size() < 2);
        out_f = (q.size() > 0) && r;
        if ((q.size() > 0) && !r && (stall_m < 15)) stall_m++;
        @(posedge clk);
        #1;
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(d);
        if (q.size() > 0) last_out = q[0];
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        data_in_valid = 1'b1;
        data_in = 32'h1234_5678;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        data_in_valid = 1'b0;
        q.delete();
        last_out = RV;
        stall_m  = 0;
    endtask

    initial begin
        logic        pend_v;
        logic [31:0] pend_d;

        // Reset with valid asserted must not load anything.
        do_reset(2);
        check("reset.data", data_out, 32'h0000_DEAD);
        check("reset.valid", {31'd0, data_out_valid}, 32'd0);
        check("reset.ready", {31'd0, data_in_ready}, 32'd1);
        check("reset.stall", {28'd0, stall_count}, 32'd0);

        // Back-to-back streaming: each word visible one cycle after its in_fire.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 32'(i), 1'b1, "stream");
            check("stream.out", data_out, 32'(i));
            check("stream.nobubble", {31'd0, data_out_valid}, 32'd1);
        end
        step(1'b0, 32'd0, 1'b1, "stream.drain");
        check("stream.empty", {31'd0, data_out_valid}, 32'd0);
        check("stream.stale", data_out, 32'h10);

        // Skid capture while downstream stalls, then drain in order.
        do_reset(1);
        step(1'b1, 32'hA, 1'b1, "skid.a");
        step(1'b1, 32'hB, 1'b0, "skid.b");
        check("skid.full_ready", {31'd0, data_in_ready}, 32'd0);
        check("skid.hold_a", data_out, 32'hA);
        step(1'b1, 32'hC, 1'b0, "skid.blocked");
        check("skid.still_a", data_out, 32'hA);
        step(1'b0, 32'h0, 1'b1, "skid.pop_a");
        check("skid.out_b", data_out, 32'hB);
        check("skid.ready_back", {31'd0, data_in_ready}, 32'd1);
        step(1'b0, 32'h0, 1'b1, "skid.pop_b");
        check("skid.empty", {31'd0, data_out_valid}, 32'd0);

        // Reset while FULL discards both buffered words.
        do_reset(1);
        step(1'b1, 32'h5, 1'b0, "mid.5");
        step(1'b1, 32'h6, 1'b0, "mid.6");
        check("mid.full", {31'd0, data_in_ready}, 32'd0);
        do_reset(1);
        check("mid.valid", {31'd0, data_out_valid}, 32'd0);
        check("mid.ready", {31'd0, data_in_ready}, 32'd1);
        step(1'b1, 32'h7, 1'b1, "mid.7");
        check("mid.first7", data_out, 32'h7);
        step(1'b0, 32'h0, 1'b1, "mid.drain");

        // Stall counter saturation under sustained backpressure.
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'(100 + i), 1'b0, "stall");
        end
        check("stall.final", {28'd0, stall_count}, STALL_EN ? 32'd15 : 32'd0);

        // Random traffic with upstream valid-hold rule.
        do_reset(1);
        pend_v = 1'b0;
        pend_d = 32'd0;
        for (int i = 0; i < 10000; i++) begin
            logic        v;
            logic [31:0] d;
            logic        r;
            if (pend_v) begin
                v = 1'b1;
                d = pend_d;
            end else begin
                v = 1'($urandom_range(0, 1));
                d = $urandom;
            end
            r = 1'($urandom_range(0, 1));
            pend_v = v && (q.size() >= 2);
            pend_d = d;
            step(v, d, r, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
